scpad_dram_req_gen: RTL and testbench
=====================================

# scpad_dram_req_gen

Scratchpad backend request generator: accepts one transfer descriptor at a time from the scratchpad scheduler and expands it into a stream of per-beat DRAM requests. For each beat it drives address, id, sub_id, vector mask and direction into the DRAM request queue. It obeys that queue's full/stall back-pressure and holds until the queue reports the transaction complete before taking the next descriptor. It sits directly upstream of the DRAM request queue, between the scheduler and the queue.

## Interface
Parameters:
- DRAM_ADDR_WIDTH, 32, DRAM byte address width
- DRAM_ID_WIDTH, 6, request id width
- DRAM_VECTOR_MASK, 32, per-beat element mask width
- BEAT_BYTES, 64, bytes per beat; power of two

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- desc_valid  in  1  scheduler descriptor valid
- desc_ready  out  1  descriptor accepted when desc_valid & desc_ready
- desc_write  in  1  1 = scratchpad store, i.e. a DRAM write
- desc_base_addr  in  DRAM_ADDR_WIDTH  byte address of row 0
- desc_row_stride  in  DRAM_ADDR_WIDTH  byte distance between row bases
- desc_num_rows  in  8  row count; 0 is legal
- desc_num_req  in  3  beats per row minus 1
- desc_tail_mask  in  DRAM_VECTOR_MASK  mask applied to the last beat of every row
- sched_valid  out  1  beat valid toward the queue
- sched_write  out  1  latched desc_write
- dram_addr  out  DRAM_ADDR_WIDTH  beat address
- id  out  DRAM_ID_WIDTH  row id
- sub_id  out  3  beat index within the row
- num_request  out  3  latched desc_num_req
- dram_vector_mask  out  DRAM_VECTOR_MASK  all-ones, or the tail mask on the last beat
- initial_request_done  out  1  high from first-beat acceptance until the transaction ends
- dram_queue_full  in  1  queue cannot accept
- be_stall  in  1  global backend stall
- transaction_complete  in  1  queue pulse: all beats of the transaction are retired
- txn_done  out  1  one-cycle pulse to the scheduler when the descriptor finishes

## Operation
- A beat is accepted when sched_valid & !dram_queue_full & !be_stall.
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE:
  - desc_ready = 1.
  - On accept, latch all desc_* fields and set row_base = desc_base_addr, sub_id = 0, row_cnt = 0.
  - If desc_num_rows = 0, pulse txn_done next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - sched_valid = 1.
  - dram_addr = row_base + sub_id*BEAT_BYTES, computed modulo 2^DRAM_ADDR_WIDTH (wraps silently).
  - On accept with sub_id < num_request: sub_id increments.
  - On accept with sub_id = num_request (end of row): sub_id resets to 0, row_base += row_stride (wrapping), row_cnt increments, id increments.
  - On the last beat of the last row, go to DRAIN.
- DRAIN:
  - sched_valid = 0.
  - Wait for transaction_complete, then pulse txn_done and go to IDLE.
- id is a free-running DRAM_ID_WIDTH counter that persists across descriptors and wraps from all-ones to 0. Each row consumes one id.
- transaction_complete is latched into a sticky flag whenever seen in ISSUE or DRAIN. DRAIN exits on either the flag or the live pulse. The flag clears on the exit to IDLE.
- transaction_complete is ignored in IDLE.
- While sched_valid is high and the beat is not accepted, every beat output holds stable.

## Timing
- Reset: all outputs 0 (desc_ready also 0 during reset); state IDLE; id counter 0; sticky flag 0. desc_ready rises in the first cycle after rst deasserts.
- Descriptor accepted at edge N: first sched_valid at cycle N+1.
- Zero stall: one beat per cycle. Beats = rows × (num_request+1).
- Last beat accepted at edge M: DRAIN from M+1. transaction_complete sampled at edge K gives txn_done high in cycle K+1, and desc_ready high from K+1.
- Back-to-back descriptors: the next descriptor may be accepted in the same cycle txn_done is high.
- be_stall and dram_queue_full have identical effect: no accept, outputs hold, no FSM advance.
- rst asserted mid-transaction: immediate return to reset values. The in-flight descriptor is dropped and no txn_done is produced.

## Structure
- scpad_pkg holds:
  - DRAM_ADDR_WIDTH, DRAM_ID_WIDTH, DRAM_VECTOR_MASK, BEAT_BYTES
  - a scpad_dram_desc_t packed struct: write, base_addr, row_stride, num_rows, num_req, tail_mask
  - a gen_state_t enum: IDLE, ISSUE, DRAIN
- One sub-module is natural: scpad_dram_addr_walk holds row_base, sub_id and row_cnt, and produces dram_addr, last_beat and last_row.

## Test plan
- Base 0x1000, stride 0x400, 2 rows, num_req 1, no stall:
  - Response: 4 beats at 0x1000, 0x1040, 0x1400, 0x1440.
  - ids 0, 0, 1, 1; sub_id 0, 1, 0, 1.
  - Mask 0xFFFFFFFF, tail, 0xFFFFFFFF, tail.
  - transaction_complete pulse gives txn_done one cycle later.
- dram_queue_full held for 5 cycles on beat 2: beat 2 outputs stable for all 5 cycles, and no beat is lost or duplicated.
- be_stall toggled every other cycle over an 8-beat descriptor: exactly 8 acceptances in order.
- desc_num_rows = 0: desc_ready stays high, txn_done pulses one cycle after accept, and sched_valid never rises.
- Base 0xFFFFFFC0, 1 row, num_req 1: second beat address is 0x00000000. Also, 70 rows of num_req 0 drive id through 63 → 0.
- rst pulsed during ISSUE: all outputs 0 while rst is high, and the next descriptor starts with id 0 and a clean beat sequence.

Source files
------------

// File: rtl/scpad_pkg.sv
// rtl/scpad_pkg.sv - shared widths, descriptor type and FSM state for the DRAM request generator
package scpad_pkg;
  localparam int DRAM_ADDR_WIDTH  = 32;
  localparam int DRAM_ID_WIDTH    = 6;
  localparam int DRAM_VECTOR_MASK = 32;
  localparam int BEAT_BYTES       = 64;
  localparam int BEAT_SHIFT       = $clog2(BEAT_BYTES);

  typedef struct packed {
    logic                        write;
    logic [DRAM_ADDR_WIDTH-1:0]  base_addr;
    logic [DRAM_ADDR_WIDTH-1:0]  row_stride;
    logic [7:0]                  num_rows;
    logic [2:0]                  num_req;
    logic [DRAM_VECTOR_MASK-1:0] tail_mask;
  } scpad_dram_desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } gen_state_t;

  function automatic logic [DRAM_ADDR_WIDTH-1:0] beat_offset(input logic [2:0] sub);
    return DRAM_ADDR_WIDTH'(sub) << BEAT_SHIFT;
  endfunction
endpackage

// File: rtl/scpad_dram_req_gen_if.sv
// rtl/scpad_dram_req_gen_if.sv - descriptor, beat and completion signals of the request generator
interface scpad_dram_req_gen_if;
  import scpad_pkg::*;

  logic                        desc_valid;
  logic                        desc_ready;
  logic                        desc_write;
  logic [DRAM_ADDR_WIDTH-1:0]  desc_base_addr;
  logic [DRAM_ADDR_WIDTH-1:0]  desc_row_stride;
  logic [7:0]                  desc_num_rows;
  logic [2:0]                  desc_num_req;
  logic [DRAM_VECTOR_MASK-1:0] desc_tail_mask;
  logic                        sched_valid;
  logic                        sched_write;
  logic [DRAM_ADDR_WIDTH-1:0]  dram_addr;
  logic [DRAM_ID_WIDTH-1:0]    id;
  logic [2:0]                  sub_id;
  logic [2:0]                  num_request;
  logic [DRAM_VECTOR_MASK-1:0] dram_vector_mask;
  logic                        initial_request_done;
  logic                        dram_queue_full;
  logic                        be_stall;
  logic                        transaction_complete;
  logic                        txn_done;

  modport master (
    input  desc_valid, desc_write, desc_base_addr, desc_row_stride, desc_num_rows,
           desc_num_req, desc_tail_mask, dram_queue_full, be_stall, transaction_complete,
    output desc_ready, sched_valid, sched_write, dram_addr, id, sub_id, num_request,
           dram_vector_mask, initial_request_done, txn_done
  );

  modport slave (
    output desc_valid, desc_write, desc_base_addr, desc_row_stride, desc_num_rows,
           desc_num_req, desc_tail_mask, dram_queue_full, be_stall, transaction_complete,
    input  desc_ready, sched_valid, sched_write, dram_addr, id, sub_id, num_request,
           dram_vector_mask, initial_request_done, txn_done
  );
endinterface

// File: rtl/scpad_dram_addr_walk.sv
// rtl/scpad_dram_addr_walk.sv - row/beat address walker: row_base, sub_id and row count
module scpad_dram_addr_walk
  import scpad_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       advance,
  input  logic [DRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [DRAM_ADDR_WIDTH-1:0] row_stride,
  input  logic [7:0]                 num_rows,
  input  logic [2:0]                 num_req,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [2:0]                 sub_id,
  output logic                       last_beat,
  output logic                       last_row
);
  logic [DRAM_ADDR_WIDTH-1:0] row_base;
  logic [DRAM_ADDR_WIDTH-1:0] stride_q;
  logic [7:0]                 rows_q;
  logic [7:0]                 row_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      row_cnt  <= '0;
      sub_id   <= '0;
    end else if (load) begin
      row_base <= base_addr;
      stride_q <= row_stride;
      rows_q   <= num_rows;
      row_cnt  <= '0;
      sub_id   <= '0;
    end else if (advance) begin
      if (last_beat) begin
        sub_id   <= '0;
        row_base <= row_base + stride_q;
        row_cnt  <= row_cnt + 8'd1;
      end else begin
        sub_id   <= sub_id + 3'd1;
      end
    end
  end

  // num_req comes from the parent's latched copy; only valid while a descriptor is active
  assign dram_addr = row_base + beat_offset(sub_id);
  assign last_beat = (sub_id == num_req);
  assign last_row  = (row_cnt == rows_q - 8'd1);
endmodule

// File: rtl/scpad_dram_req_gen.sv
// rtl/scpad_dram_req_gen.sv - expands one scheduler descriptor into per-beat DRAM requests
module scpad_dram_req_gen
  import scpad_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  scpad_dram_req_gen_if.master bus
);
  gen_state_t                  state;
  scpad_dram_desc_t            desc_in;
  logic                        write_q;
  logic [2:0]                  num_req_q;
  logic [DRAM_VECTOR_MASK-1:0] tail_q;
  logic [DRAM_ID_WIDTH-1:0]    id_q;
  logic                        cpl_seen;
  logic                        done_q;
  logic                        init_q;
  logic                        desc_fire;
  logic                        beat_fire;
  logic                        last_beat;
  logic                        last_row;
  logic [DRAM_ADDR_WIDTH-1:0]  walk_addr;
  logic [2:0]                  walk_sub;

  assign desc_in = '{write: bus.desc_write, base_addr: bus.desc_base_addr,
                     row_stride: bus.desc_row_stride, num_rows: bus.desc_num_rows,
                     num_req: bus.desc_num_req, tail_mask: bus.desc_tail_mask};

  assign desc_fire = bus.desc_valid & bus.desc_ready;
  assign beat_fire = bus.sched_valid & ~bus.dram_queue_full & ~bus.be_stall;

  scpad_dram_addr_walk u_walk (
    .clk        (clk),
    .rst        (rst),
    .load       (desc_fire),
    .advance    (beat_fire),
    .base_addr  (desc_in.base_addr),
    .row_stride (desc_in.row_stride),
    .num_rows   (desc_in.num_rows),
    .num_req    (num_req_q),
    .dram_addr  (walk_addr),
    .sub_id     (walk_sub),
    .last_beat  (last_beat),
    .last_row   (last_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      num_req_q <= '0;
      tail_q    <= '0;
      id_q      <= '0;
      cpl_seen  <= 1'b0;
      done_q    <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_fire) begin
            write_q   <= desc_in.write;
            num_req_q <= desc_in.num_req;
            tail_q    <= desc_in.tail_mask;
            if (desc_in.num_rows == 8'd0) done_q <= 1'b1;
            else                          state  <= ISSUE;
          end
        end
        ISSUE: begin
          // completion may arrive before the last beat is issued; remember it for DRAIN
          if (bus.transaction_complete) cpl_seen <= 1'b1;
          if (beat_fire) begin
            init_q <= 1'b1;
            if (last_beat) begin
              id_q <= id_q + DRAM_ID_WIDTH'(1);
              if (last_row) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cpl_seen | bus.transaction_complete) begin
            done_q   <= 1'b1;
            cpl_seen <= 1'b0;
            init_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.desc_ready           = (state == IDLE) & ~rst;
  assign bus.sched_valid          = (state == ISSUE);
  assign bus.sched_write          = write_q;
  assign bus.dram_addr            = walk_addr;
  assign bus.id                   = id_q;
  assign bus.sub_id               = walk_sub;
  assign bus.num_request          = num_req_q;
  assign bus.dram_vector_mask     = !bus.sched_valid ? '0 : (last_beat ? tail_q : '1);
  assign bus.initial_request_done = init_q;
  assign bus.txn_done             = done_q;
endmodule

// File: tb/tb_scpad_dram_req_gen.sv
// tb/tb_scpad_dram_req_gen.sv - directed vector bench for scpad_dram_req_gen
module tb_scpad_dram_req_gen;
  import scpad_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scpad_dram_req_gen_if bus();
  scpad_dram_req_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  id;
    logic [2:0]  sub;
    logic [31:0] mask;
    logic        wr;
    logic [2:0]  nreq;
  } beat_t;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] base;
    logic [31:0] stride;
    int          rows;
    int          nreq;
    logic [31:0] tail;
    bit          sticky;
  } tvec_t;

  beat_t      got[$];
  beat_t      tbl[4];
  tvec_t      vecs[3];
  logic [5:0] exp_id;

  always @(negedge clk)
    if (!rst && bus.sched_valid && !bus.dram_queue_full && !bus.be_stall)
      got.push_back('{bus.dram_addr, bus.id, bus.sub_id, bus.dram_vector_mask,
                      bus.sched_write, bus.num_request});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic wr, input logic [31:0] base, input logic [31:0] stride,
                           input int rows, input int nreq, input logic [31:0] tail);
    int n = 0;
    while (!bus.desc_ready && n < 50) begin tick(); n++; end
    chk("desc_ready_before_send", bus.desc_ready, 1);
    bus.desc_write      = wr;
    bus.desc_base_addr  = base;
    bus.desc_row_stride = stride;
    bus.desc_num_rows   = 8'(rows);
    bus.desc_num_req    = 3'(nreq);
    bus.desc_tail_mask  = tail;
    bus.desc_valid      = 1'b1;
    tick();
    bus.desc_valid      = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n);
    int c = 0;
    while (got.size() < n && c < 400) begin tick(); c++; end
    chk({name, " beat_count"}, got.size(), n);
  endtask

  task automatic finish_drain(input string name, input bit sticky);
    chk({name, " drain_valid"}, bus.sched_valid, 0);
    chk({name, " drain_init_done"}, bus.initial_request_done, 1);
    chk({name, " drain_no_done"}, bus.txn_done, 0);
    if (!sticky) bus.transaction_complete = 1'b1;
    tick();
    bus.transaction_complete = 1'b0;
    chk({name, " txn_done"}, bus.txn_done, 1);
    chk({name, " ready_after"}, bus.desc_ready, 1);
    chk({name, " init_done_clr"}, bus.initial_request_done, 0);
    tick();
    chk({name, " txn_done_pulse"}, bus.txn_done, 0);
  endtask

  task automatic check_model(input string name, input logic wr, input logic [31:0] base,
                             input logic [31:0] stride, input int rows, input int nreq,
                             input logic [31:0] tail);
    int beats = rows * (nreq + 1);
    chk({name, " total_beats"}, got.size(), beats);
    for (int i = 0; i < beats && i < got.size(); i++) begin
      int r = i / (nreq + 1);
      int s = i % (nreq + 1);
      logic [31:0] ea = base + 32'(r) * stride + 32'(s) * 32'd64;
      logic [5:0]  ei = exp_id + 6'(r);
      logic [31:0] em = (s == nreq) ? tail : 32'hFFFF_FFFF;
      chk($sformatf("%s beat%0d addr/id/sub", name, i),
          {got[i].addr, got[i].id, got[i].sub}, {ea, ei, 3'(s)});
      chk($sformatf("%s beat%0d mask/wr/nreq", name, i),
          {got[i].mask, got[i].wr, got[i].nreq}, {em, wr, 3'(nreq)});
    end
    exp_id = exp_id + 6'(rows);
    got.delete();
  endtask

  task automatic run_basic(input string name);
    send_desc(1'b1, 32'h1000, 32'h400, 2, 1, 32'h0000_FFFF);
    wait_beats(name, 4);
    finish_drain(name, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk($sformatf("%s beat%0d addr", name, i), got[i].addr, tbl[i].addr);
        chk($sformatf("%s beat%0d id/sub", name, i), {got[i].id, got[i].sub}, {tbl[i].id, tbl[i].sub});
        chk($sformatf("%s beat%0d mask", name, i), got[i].mask, tbl[i].mask);
        chk($sformatf("%s beat%0d wr/nreq", name, i), {got[i].wr, got[i].nreq}, {tbl[i].wr, tbl[i].nreq});
      end
    end
    exp_id = exp_id + 6'd2;
    got.delete();
  endtask

  initial begin
    tbl[0] = '{32'h0000_1000, 6'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 3'd1};
    tbl[1] = '{32'h0000_1040, 6'd0, 3'd1, 32'h0000_FFFF, 1'b1, 3'd1};
    tbl[2] = '{32'h0000_1400, 6'd1, 3'd0, 32'hFFFF_FFFF, 1'b1, 3'd1};
    tbl[3] = '{32'h0000_1440, 6'd1, 3'd1, 32'h0000_FFFF, 1'b1, 3'd1};
    vecs[0] = '{"contig", 1'b0, 32'h8000_0000, 32'h40, 3, 7, 32'h0000_00FF, 1'b0};
    vecs[1] = '{"addr_wrap", 1'b1, 32'hFFFF_FFC0, 32'h400, 1, 1, 32'h0000_0003, 1'b1};
    vecs[2] = '{"id_wrap", 1'b0, 32'h0010_0000, 32'h10, 70, 0, 32'h0000_0001, 1'b0};

    bus.desc_valid = 0; bus.desc_write = 0; bus.desc_base_addr = 0; bus.desc_row_stride = 0;
    bus.desc_num_rows = 0; bus.desc_num_req = 0; bus.desc_tail_mask = 0;
    bus.dram_queue_full = 0; bus.be_stall = 0; bus.transaction_complete = 0;
    exp_id = 6'd0;

    // reset state
    repeat (3) tick();
    chk("rst desc_ready", bus.desc_ready, 0);
    chk("rst valid/done/init", {bus.sched_valid, bus.txn_done, bus.initial_request_done}, 0);
    chk("rst addr/id/sub", {bus.dram_addr, bus.id, bus.sub_id}, 0);
    chk("rst mask/wr/nreq", {bus.dram_vector_mask, bus.sched_write, bus.num_request}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst desc_ready", bus.desc_ready, 1);

    run_basic("basic");

    // queue full held on beat 2
    send_desc(1'b0, 32'h2000, 32'h100, 1, 3, 32'h0000_000F);
    tick();
    tick();
    bus.dram_queue_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("full_hold c%0d addr/sub", k), {bus.dram_addr, bus.sub_id}, {32'h2080, 3'd2});
      chk($sformatf("full_hold c%0d valid/mask", k), {bus.sched_valid, bus.dram_vector_mask},
          {1'b1, 32'hFFFF_FFFF});
    end
    chk("full_hold accepted", got.size(), 2);
    bus.dram_queue_full = 1'b0;
    wait_beats("full_hold", 4);
    finish_drain("full_hold", 1'b0);
    check_model("full_hold", 1'b0, 32'h2000, 32'h100, 1, 3, 32'h0000_000F);

    // be_stall toggling, completion arrives early and must be remembered
    send_desc(1'b1, 32'h3000, 32'h200, 2, 3, 32'hAAAA_0000);
    for (int k = 0; k < 60 && got.size() < 8; k++) begin
      bus.be_stall = k[0];
      bus.transaction_complete = (k == 1);
      tick();
    end
    bus.be_stall = 1'b0;
    bus.transaction_complete = 1'b0;
    chk("stall_toggle beat_count", got.size(), 8);
    finish_drain("stall_toggle", 1'b1);
    check_model("stall_toggle", 1'b1, 32'h3000, 32'h200, 2, 3, 32'hAAAA_0000);

    // zero-row descriptors, the second one followed back-to-back by a real one
    send_desc(1'b0, 32'h5000, 32'h40, 0, 2, 32'h1);
    chk("zero_rows txn_done", {bus.txn_done, bus.desc_ready, bus.sched_valid}, 3'b110);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("zero_rows c%0d valid/done", k), {bus.sched_valid, bus.txn_done}, 0);
    end
    send_desc(1'b0, 32'h5000, 32'h40, 0, 2, 32'h1);
    chk("zero_rows2 txn_done", {bus.txn_done, bus.desc_ready}, 2'b11);
    chk("zero_rows no beats", got.size(), 0);

    for (int v = 0; v < 3; v++) begin
      send_desc(vecs[v].wr, vecs[v].base, vecs[v].stride, vecs[v].rows, vecs[v].nreq, vecs[v].tail);
      if (vecs[v].sticky) begin
        bus.transaction_complete = 1'b1;
        tick();
        bus.transaction_complete = 1'b0;
      end
      wait_beats(vecs[v].name, vecs[v].rows * (vecs[v].nreq + 1));
      finish_drain(vecs[v].name, vecs[v].sticky);
      check_model(vecs[v].name, vecs[v].wr, vecs[v].base, vecs[v].stride, vecs[v].rows,
                  vecs[v].nreq, vecs[v].tail);
    end
    chk("id after wrap", bus.id, 6'd15);

    // reset in the middle of ISSUE
    send_desc(1'b1, 32'h7000, 32'h800, 4, 3, 32'h0000_0F0F);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst desc_ready/valid/done/init",
        {bus.desc_ready, bus.sched_valid, bus.txn_done, bus.initial_request_done}, 0);
    chk("midrst addr/id/sub", {bus.dram_addr, bus.id, bus.sub_id}, 0);
    chk("midrst mask/wr/nreq", {bus.dram_vector_mask, bus.sched_write, bus.num_request}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst post desc_ready/done", {bus.desc_ready, bus.txn_done}, 2'b10);
    got.delete();
    exp_id = 6'd0;
    run_basic("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
